// File: rtl/sp_ram_ft.sv
// sp_ram_ft: single-port SRAM model with a per-word 2-bit fault map, automatic
//   boosted re-read of faulty words and a saturating faulty-read counter.
// Latency: clean read data one cycle after accept; faulty read data after
//   1+RETRY_CYCLES cycles. Writes complete at the accept edge.
// Backpressure: gnt_o drops for the whole retry window; requests are only
//   accepted while gnt_o is high.
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_i/we_i/be_i/addr_i/wdata_i   access request (write when we_i=1)
//   gnt_o                            request accepted this cycle (FSM idle)
//   rvalid_o/rdata_o/rerr_o          read response, rerr_o=1 on hard fault
//   error_flag_o/boost_o             faulty-read pulse / retry-in-progress
//   fm_we_i/fm_addr_i/fm_code_i      fault-map write port
//   err_clr_i/err_cnt_o              faulty-read counter clear / value
module sp_ram_ft #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WORDS    = 256,
  parameter int RETRY_CYCLES = 2,
  parameter logic [2*NUM_WORDS-1:0] FAULT_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rerr_o,
  output logic                    error_flag_o,
  output logic                    boost_o,
  input  logic                    fm_we_i,
  input  logic [ADDR_WIDTH-1:0]   fm_addr_i,
  input  logic [1:0]              fm_code_i,
  input  logic                    err_clr_i,
  output logic [15:0]             err_cnt_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_WORDS < 2) ? 1 : $clog2(NUM_WORDS);
  localparam int CNT_W = (RETRY_CYCLES < 2) ? 1 : $clog2(RETRY_CYCLES + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_RETRY = 1'b1
  } state_t;

  // Storage has no reset: contents must survive rst.
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [1:0]            fm_q [NUM_WORDS];
  logic [1:0]            fm_d [NUM_WORDS];
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      raddr_q, raddr_d;
  logic                  hard_q, hard_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;
  logic                  eflag_q, eflag_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic                  in_range, fm_in_range;
  logic [IDX_W-1:0]      a_idx, fm_idx;
  logic                  accept, wr_en;
  logic [1:0]            code;
  logic [DATA_WIDTH-1:0] rd_word;

  assign in_range    = (32'(addr_i) < NUM_WORDS);
  assign fm_in_range = (32'(fm_addr_i) < NUM_WORDS);
  assign a_idx       = addr_i[IDX_W-1:0];
  assign fm_idx      = fm_addr_i[IDX_W-1:0];

  assign gnt_o  = (state_q == ST_IDLE);
  assign accept = req_i && gnt_o;
  // rst gates the write because the array itself has no reset branch.
  assign wr_en  = accept && we_i && in_range && !rst;

  // Out-of-range reads behave as clean reads of zero.
  assign code    = in_range ? fm_q[a_idx] : 2'b00;
  assign rd_word = in_range ? mem[a_idx] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be_i[k]) mem[a_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Fault map: combinational reads above see the pre-edge code, so a read
  // accepted together with a map write to the same word uses the old code.
  always_comb begin
    fm_d = fm_q;
    if (fm_we_i && fm_in_range) fm_d[fm_idx] = fm_code_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    hard_d    = hard_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    eflag_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && !we_i) begin
          if (code == 2'b00) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rerr_d   = 1'b0;
          end else begin
            state_d = ST_RETRY;
            cnt_d   = CNT_W'(RETRY_CYCLES);
            raddr_d = a_idx;
            hard_d  = code[1];
            eflag_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      ST_RETRY: begin
        // Last boosted cycle: the re-read word becomes the response.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rdata_d  = mem[raddr_q];
          rerr_d   = hard_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_clr_i) err_cnt_d = 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) fm_q[i] <= FAULT_INIT[2*i +: 2];
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      raddr_q   <= '0;
      hard_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      eflag_q   <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      fm_q      <= fm_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raddr_q   <= raddr_d;
      hard_q    <= hard_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      eflag_q   <= eflag_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign rerr_o       = rerr_q;
  assign error_flag_o = eflag_q;
  assign boost_o      = (state_q == ST_RETRY);
  assign err_cnt_o    = err_cnt_q;

endmodule
